// File: rtl/rmii_rx_deframer_pkg.sv
// rmii_rx_deframer shared definitions: FSM states, RMII framing dibits and
// CRC-32 constants (register kept in wire-order/normal orientation).
package rmii_rx_deframer_pkg;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX_PRE  = 3'd1,
        RX_DATA = 3'd2,
        RX_END  = 3'd3,
        RX_DROP = 3'd4
    } rx_state_t;

    localparam logic [1:0] PRE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT = 2'b11;

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

endpackage

// File: rtl/rmii_rx_deframer_if.sv
// rmii_rx_deframer_if: RMII receive pins plus the deframed byte stream.
// master = PHY/consumer side, slave = deframer side.
interface rmii_rx_deframer_if #(
    parameter int CNT_W = 11
);
    logic             i_crs_dv;
    logic [1:0]       i_rxd;
    logic [7:0]       o_data;
    logic             o_byte_valid;
    logic             o_sof;
    logic             o_eof;
    logic             o_frame_err;
    logic             o_crc_err;
    logic [CNT_W-1:0] o_byte_count;

    modport master (
        output i_crs_dv, i_rxd,
        input  o_data, o_byte_valid, o_sof, o_eof,
        input  o_frame_err, o_crc_err, o_byte_count
    );

    modport slave (
        input  i_crs_dv, i_rxd,
        output o_data, o_byte_valid, o_sof, o_eof,
        output o_frame_err, o_crc_err, o_byte_count
    );
endinterface

// File: rtl/rmii_rx_deframer_crc32_dibit.sv
// Combinational CRC-32 advance by one RMII dibit (bit 0 first on the wire).
// Only built when RMII_RX_CRC_CHECK_EN is defined.
`ifdef RMII_RX_CRC_CHECK_EN
module rmii_rx_deframer_crc32_dibit
    import rmii_rx_deframer_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_next
);
    logic [31:0] mid;

    always_comb begin
        mid      = {crc[30:0], 1'b0}
                 ^ ((crc[31] ^ dibit[0]) ? CRC_POLY : 32'h0);
        crc_next = {mid[30:0], 1'b0}
                 ^ ((mid[31] ^ dibit[1]) ? CRC_POLY : 32'h0);
    end
endmodule
`endif

// File: rtl/rmii_rx_deframer.sv
// rmii_rx_deframer: RMII receive deframer (preamble/SFD strip, byte assembly).
// Define RMII_RX_CRC_CHECK_EN to enable FCS residue checking on o_crc_err.
module rmii_rx_deframer
    import rmii_rx_deframer_pkg::*;
#(
    parameter int MIN_PREAMBLE = 8,
    parameter int MAX_BYTES    = 1522,
    parameter int CNT_W        = 11
) (
    input logic               i_clock,
    input logic               i_reset,
    rmii_rx_deframer_if.slave bus
);
    localparam logic [4:0]       MIN_PRE = 5'(MIN_PREAMBLE);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    logic             crs_q;
    logic [1:0]       rxd_q;
    rx_state_t        state, state_d;
    logic [4:0]       pre_cnt, pre_cnt_d;
    logic [1:0]       dib_idx, dib_idx_d;
    logic [5:0]       shreg, shreg_d;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             ferr_q, ferr_d;
    logic             cerr_q, cerr_d;
    logic             crc_bad;

`ifdef RMII_RX_CRC_CHECK_EN
    logic [31:0] crc, crc_d, crc_next;

    rmii_rx_deframer_crc32_dibit u_crc32_dibit (
        .crc      (crc),
        .dibit    (rxd_q),
        .crc_next (crc_next)
    );

    assign crc_bad = (crc != CRC_RESIDUE);

    always_ff @(posedge i_clock) begin
        if (!i_reset) crc <= CRC_INIT;
        else          crc <= crc_d;
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        pre_cnt_d  = pre_cnt;
        dib_idx_d  = dib_idx;
        shreg_d    = shreg;
        byte_cnt_d = byte_cnt;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        ferr_d     = 1'b0;
        cerr_d     = 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
        crc_d      = crc;
`endif
        unique case (state)
            RX_IDLE, RX_END: begin
                // END also acts as IDLE so a 1-cycle gap loses no dibit
                if (state == RX_END) begin
                    eof_d  = 1'b1;
                    ferr_d = (dib_idx != 2'd0) || (byte_cnt == '0);
                    cerr_d = !ferr_d && crc_bad;
                end
                state_d = RX_IDLE;
                if (crs_q) begin
                    if (rxd_q == PRE_DIBIT) begin
                        state_d   = RX_PRE;
                        pre_cnt_d = 5'd1;
                    end else begin
                        state_d = RX_DROP;
                    end
                end
            end
            RX_PRE: begin
                if (!crs_q) begin
                    state_d = RX_IDLE;
                end else if (rxd_q == PRE_DIBIT) begin
                    if (pre_cnt != 5'd31) pre_cnt_d = pre_cnt + 5'd1;
                end else if (rxd_q == SFD_DIBIT && pre_cnt >= MIN_PRE) begin
                    state_d    = RX_DATA;
                    dib_idx_d  = 2'd0;
                    byte_cnt_d = '0;
`ifdef RMII_RX_CRC_CHECK_EN
                    crc_d      = CRC_INIT;
`endif
                end else begin
                    state_d = RX_DROP;
                end
            end
            RX_DATA: begin
                if (!crs_q) begin
                    state_d = RX_END;
                end else begin
                    shreg_d   = {rxd_q, shreg[5:2]};
                    dib_idx_d = dib_idx + 2'd1;
`ifdef RMII_RX_CRC_CHECK_EN
                    crc_d     = crc_next;
`endif
                    if (dib_idx == 2'd3) begin
                        if (byte_cnt == MAX_CNT) begin
                            eof_d   = 1'b1;
                            ferr_d  = 1'b1;
                            state_d = RX_DROP;
                        end else begin
                            data_d     = {rxd_q, shreg};
                            valid_d    = 1'b1;
                            sof_d      = (byte_cnt == '0);
                            byte_cnt_d = byte_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            RX_DROP: begin
                if (!crs_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            crs_q    <= 1'b0;
            rxd_q    <= 2'b00;
            state    <= RX_IDLE;
            pre_cnt  <= 5'd0;
            dib_idx  <= 2'd0;
            shreg    <= 6'd0;
            byte_cnt <= '0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            ferr_q   <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            crs_q    <= bus.i_crs_dv;
            rxd_q    <= bus.i_rxd;
            state    <= state_d;
            pre_cnt  <= pre_cnt_d;
            dib_idx  <= dib_idx_d;
            shreg    <= shreg_d;
            byte_cnt <= byte_cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            ferr_q   <= ferr_d;
            cerr_q   <= cerr_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_byte_valid = valid_q;
    assign bus.o_sof        = sof_q;
    assign bus.o_eof        = eof_q;
    assign bus.o_frame_err  = ferr_q;
    assign bus.o_crc_err    = cerr_q;
    assign bus.o_byte_count = byte_cnt;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Bench for rmii_rx_deframer: two instances (MAX_BYTES 1522 and 8) share the
// RMII stimulus; outputs are compared with a frame-level reference model.
module tb_rmii_rx_deframer;

    localparam int MIN_PRE = 8;
`ifdef RMII_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       sof;
    } bev_t;

    typedef struct {
        logic        ferr;
        logic        cerr;
        logic [10:0] cnt;
    } eev_t;

    logic       clk;
    logic       rst_n;
    logic       crs_dv;
    logic [1:0] rxd;

    int total = 0;
    int bad   = 0;

    logic [1:0] stim[$];
    logic [7:0] pay[$];
    bev_t       exp_b[2][$];
    bev_t       got_b[2][$];
    eev_t       exp_e[2][$];
    eev_t       got_e[2][$];

    rmii_rx_deframer_if #(.CNT_W(11)) bus_a ();
    rmii_rx_deframer_if #(.CNT_W(11)) bus_b ();

    assign bus_a.i_crs_dv = crs_dv;
    assign bus_a.i_rxd    = rxd;
    assign bus_b.i_crs_dv = crs_dv;
    assign bus_b.i_rxd    = rxd;

    rmii_rx_deframer #(
        .MIN_PREAMBLE (8),
        .MAX_BYTES    (1522),
        .CNT_W        (11)
    ) u_dut_a (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus_a)
    );

    rmii_rx_deframer #(
        .MIN_PREAMBLE (8),
        .MAX_BYTES    (8),
        .CNT_W        (11)
    ) u_dut_b (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic capture(int k, logic bv, logic sof, logic [7:0] d,
                           logic eof, logic fe, logic ce, logic [10:0] cnt);
        bev_t be;
        eev_t ee;
        if (bv || sof) begin
            be.d = d;
            be.sof = sof;
            got_b[k].push_back(be);
        end
        if (eof || fe || ce) begin
            ee.ferr = fe;
            ee.cerr = ce;
            ee.cnt = cnt;
            got_e[k].push_back(ee);
        end
    endtask

    always @(negedge clk) begin
        capture(0, bus_a.o_byte_valid, bus_a.o_sof, bus_a.o_data,
                bus_a.o_eof, bus_a.o_frame_err, bus_a.o_crc_err,
                bus_a.o_byte_count);
        capture(1, bus_b.o_byte_valid, bus_b.o_sof, bus_b.o_data,
                bus_b.o_eof, bus_b.o_frame_err, bus_b.o_crc_err,
                bus_b.o_byte_count);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Ethernet FCS of the first n bytes (reflected CRC-32, final inversion)
    function automatic logic [31:0] fcs_of(logic [7:0] b[$], int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(logic [7:0] b[$]);
        int n;
        logic [31:0] f;
        n = b.size();
        if (n < 4) return 1'b0;
        f = fcs_of(b, n - 4);
        return {b[n-1], b[n-2], b[n-3], b[n-4]} == f;
    endfunction

    // Frame-level model: count leading preamble dibits, require SFD, then
    // group the remaining dibits into bytes and apply length/error rules.
    task automatic model(int k, int maxb);
        int p;
        int rem;
        int nb;
        logic [7:0] by[$];
        bev_t be;
        eev_t ee;
        p = 0;
        while (p < stim.size() && stim[p] == 2'b01) p++;
        if (p < MIN_PRE || p >= stim.size() || stim[p] != 2'b11) return;
        p++;
        for (int i = p; i + 3 < stim.size(); i += 4)
            by.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
        rem = (stim.size() - p) % 4;
        nb = by.size();
        for (int i = 0; i < nb && i < maxb; i++) begin
            be.d = by[i];
            be.sof = (i == 0);
            exp_b[k].push_back(be);
        end
        if (nb > maxb) begin
            ee.ferr = 1'b1;
            ee.cerr = 1'b0;
            ee.cnt = 11'(maxb);
        end else begin
            ee.ferr = (rem != 0) || (nb == 0);
            ee.cerr = CRC_EN && !ee.ferr && !fcs_ok(by);
            ee.cnt = 11'(nb);
        end
        exp_e[k].push_back(ee);
    endtask

    task automatic add_pre(int n);
        repeat (n) stim.push_back(2'b01);
    endtask

    task automatic add_pay();
        foreach (pay[i]) begin
            stim.push_back(pay[i][1:0]);
            stim.push_back(pay[i][3:2]);
            stim.push_back(pay[i][5:4]);
            stim.push_back(pay[i][7:6]);
        end
    endtask

    task automatic rand_pay(int n);
        pay.delete();
        repeat (n) pay.push_back(8'($urandom));
    endtask

    task automatic add_fcs();
        logic [31:0] f;
        f = fcs_of(pay, pay.size());
        pay.push_back(f[7:0]);
        pay.push_back(f[15:8]);
        pay.push_back(f[23:16]);
        pay.push_back(f[31:24]);
    endtask

    task automatic drive(int gap);
        foreach (stim[i]) begin
            @(negedge clk);
            crs_dv = 1'b1;
            rxd = stim[i];
        end
        repeat (gap) begin
            @(negedge clk);
            crs_dv = 1'b0;
            rxd = 2'b00;
        end
        stim.delete();
    endtask

    task automatic run(int gap);
        model(0, 1522);
        model(1, 8);
        drive(gap);
    endtask

    task automatic std_frame(int pre, int gap);
        add_pre(pre);
        stim.push_back(2'b11);
        add_pay();
        run(gap);
    endtask

    task automatic check_all(string tag);
        logic [10:0] cnow[2];
        cnow[0] = bus_a.o_byte_count;
        cnow[1] = bus_b.o_byte_count;
        for (int k = 0; k < 2; k++) begin
            int nb;
            int ne;
            chk($sformatf("%s.u%0d.nbytes", tag, k),
                got_b[k].size(), exp_b[k].size());
            nb = (got_b[k].size() < exp_b[k].size()) ?
                 got_b[k].size() : exp_b[k].size();
            for (int i = 0; i < nb; i++) begin
                chk($sformatf("%s.u%0d.data%0d", tag, k, i),
                    got_b[k][i].d, exp_b[k][i].d);
                chk($sformatf("%s.u%0d.sof%0d", tag, k, i),
                    got_b[k][i].sof, exp_b[k][i].sof);
            end
            chk($sformatf("%s.u%0d.neof", tag, k),
                got_e[k].size(), exp_e[k].size());
            ne = (got_e[k].size() < exp_e[k].size()) ?
                 got_e[k].size() : exp_e[k].size();
            for (int i = 0; i < ne; i++) begin
                chk($sformatf("%s.u%0d.ferr%0d", tag, k, i),
                    got_e[k][i].ferr, exp_e[k][i].ferr);
                chk($sformatf("%s.u%0d.cerr%0d", tag, k, i),
                    got_e[k][i].cerr, exp_e[k][i].cerr);
                chk($sformatf("%s.u%0d.cnt%0d", tag, k, i),
                    got_e[k][i].cnt, exp_e[k][i].cnt);
            end
            if (exp_e[k].size() != 0)
                chk($sformatf("%s.u%0d.held_cnt", tag, k), cnow[k],
                    exp_e[k][exp_e[k].size()-1].cnt);
            got_b[k].delete();
            exp_b[k].delete();
            got_e[k].delete();
            exp_e[k].delete();
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, ".u0.outs"},
            {bus_a.o_data, bus_a.o_byte_valid, bus_a.o_sof, bus_a.o_eof,
             bus_a.o_frame_err, bus_a.o_crc_err, bus_a.o_byte_count}, 32'h0);
        chk({tag, ".u1.outs"},
            {bus_b.o_data, bus_b.o_byte_valid, bus_b.o_sof, bus_b.o_eof,
             bus_b.o_frame_err, bus_b.o_crc_err, bus_b.o_byte_count}, 32'h0);
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        bev_t be;
        crs_dv = 1'b0;
        rxd = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pay = {8'h55, 8'hAA, 8'h01, 8'hFE};
        std_frame(16, 3);
        drain();
        check_all("frame1");

        rand_pay(5);
        std_frame(4, 3);
        rand_pay(5);
        std_frame(MIN_PRE, 3);
        drain();
        check_all("short_pre");

        rand_pay(3);
        std_frame(MIN_PRE - 1, 2);
        stim.push_back(2'b00);
        add_pre(10);
        stim.push_back(2'b11);
        add_pay();
        run(2);
        add_pre(5);
        stim.push_back(2'b10);
        add_pre(5);
        stim.push_back(2'b11);
        add_pay();
        run(2);
        rand_pay(3);
        std_frame(40, 3);
        drain();
        check_all("bad_start");

        rand_pay(4);
        add_pre(10);
        stim.push_back(2'b11);
        add_pay();
        stim.push_back(2'b10);
        stim.push_back(2'b01);
        run(3);
        add_pre(10);
        stim.push_back(2'b11);
        run(3);
        drain();
        check_all("partial");

        rand_pay(10);
        std_frame(12, 3);
        rand_pay(8);
        std_frame(12, 3);
        drain();
        check_all("oversize");

        rand_pay(2);
        add_pre(10);
        stim.push_back(2'b11);
        add_pay();
        stim.push_back(2'b11);
        drive(0);
        for (int k = 0; k < 2; k++) begin
            be.d = pay[0];
            be.sof = 1'b1;
            exp_b[k].push_back(be);
            be.d = pay[1];
            be.sof = 1'b0;
            exp_b[k].push_back(be);
        end
        @(negedge clk);
        rst_n = 1'b0;
        crs_dv = 1'b0;
        rxd = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("mid_reset");
        drain();
        check_all("mid_reset");

        rand_pay(3);
        std_frame(9, 1);
        rand_pay(6);
        std_frame(10, 1);
        rand_pay(2);
        std_frame(8, 3);
        drain();
        check_all("b2b");

        rand_pay(56);
        add_fcs();
        std_frame(14, 3);
        drain();
        check_all("crc_good");
        pay[10] = pay[10] ^ 8'h04;
        std_frame(14, 3);
        drain();
        check_all("crc_flip");

        for (int f = 0; f < 10; f++) begin
            int pre;
            int len;
            int ext;
            pre = $urandom_range(20, 6);
            len = $urandom_range(14, 0);
            ext = ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0;
            rand_pay(len);
            if (len > 0 && $urandom_range(1, 0) == 1) add_fcs();
            add_pre(pre);
            stim.push_back(2'b11);
            add_pay();
            repeat (ext) stim.push_back(2'($urandom));
            run($urandom_range(3, 1));
        end
        drain();
        check_all("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
